sequencia_jogo_param: RTL and testbench

SEQUENCIA_JOGO_PARAM -- requirements
Module: sequencia_jogo_param

---
 rtl/sequencia_jogo_param.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_sequencia_jogo_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequencia_jogo_param.sv
// Memory-game sequencer: shows a stored sequence of one-hot symbols on the
// LEDs, then checks the player's replay, one more symbol per round.
// modo 0 plays a preloaded sequence, while modo 1 lets the player append a
// new symbol after each correctly replayed round.
//
// Ports
//   clock, reset           single clock, synchronous active-high reset
//   iniciar, modo          start pulse and game mode (mode sampled on start)
//   botoes                 raw button levels
//   carrega_we/addr/dado   preload write port (only in INICIAL / FIM states)
//   leds                   symbol being shown during MOSTRA, otherwise 0
//   pronto, acertou,
//   errou, timeout         session-end flags, held in the FIM states
//   db_estado, db_rodada,
//   db_endereco            debug view of state, round and address
module sequencia_jogo_param #(
    parameter int unsigned N_BOT       = 4,
    parameter int unsigned PROF        = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned SHOW_CYC    = 500
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             modo,
    input  logic [N_BOT-1:0] botoes,
    input  logic             carrega_we,
    input  logic [AW-1:0]    carrega_addr,
    input  logic [N_BOT-1:0] carrega_dado,
    output logic [N_BOT-1:0] leds,
    output logic             pronto,
    output logic             acertou,
    output logic             errou,
    output logic             timeout,
    output logic [3:0]       db_estado,
    output logic [AW-1:0]    db_rodada,
    output logic [AW-1:0]    db_endereco
);

    localparam int unsigned IW    = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int unsigned MAXC  = (TIMEOUT_CYC > SHOW_CYC) ? TIMEOUT_CYC : SHOW_CYC;
    localparam int unsigned CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [AW-1:0] RODADA_MAX = AW'(PROF - 1);
    localparam logic [AW:0]   PROF_LIM   = (AW + 1)'(PROF);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        APAGA       = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROXIMO     = 4'h7,
        ESPERA_NOVO = 4'h8,
        ESCREVE     = 4'h9,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    rodada_q, rodada_d;
    logic [AW-1:0]    endereco_q, endereco_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             modo_q, modo_d;
    logic             first_q, first_d;
    logic             armed_q, armed_d;
    logic [N_BOT-1:0] press_q, press_d;
    logic [N_BOT-1:0] rd_q, rd_d;
    logic [N_BOT-1:0] leds_q, leds_d;
    logic             pronto_q, pronto_d;
    logic             acertou_q, acertou_d;
    logic             errou_q, errou_d;
    logic             timeout_q, timeout_d;

    logic [N_BOT-1:0] mem_q [PROF];

    logic             load_ok_c;
    logic             press_c;
    logic             mem_we_c;
    logic             mem_wr_c;
    logic [AW-1:0]    mem_waddr_c;
    logic [N_BOT-1:0] mem_wdata_c;

    function automatic logic is_onehot(input logic [N_BOT-1:0] v);
        return (v != '0) && ((v & (v - N_BOT'(1))) == '0);
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < PROF_LIM;
    endfunction

    // Press = rising edge of "any button"; armed only after a cycle with all released
    assign load_ok_c = (state_q == INICIAL) || (state_q == FIM_ACERTO) ||
                       (state_q == FIM_ERRO) || (state_q == FIM_TIMEOUT);
    assign press_c   = armed_q && (botoes != '0);

    // Memory write port: the player-extension write takes priority over preload
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = carrega_addr;
        mem_wdata_c = carrega_dado;
        if (state_q == ESCREVE) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = first_q ? '0 : rodada_q + AW'(1);
            mem_wdata_c = press_q;
        end else if (carrega_we && load_ok_c) begin
            mem_we_c = 1'b1;
        end
    end

    assign mem_wr_c = mem_we_c && in_range(mem_waddr_c);

    // Memory array: no reset so contents survive a game reset
    always_ff @(posedge clock) begin
        if (mem_wr_c) begin
            mem_q[IW'(mem_waddr_c)] <= mem_wdata_c;
        end
    end

    // Read data registered from the next address, so rd_q always matches
    // endereco_q; a same-cycle write is forwarded (ESCREVE -> MOSTRA at addr 0)
    always_comb begin
        rd_d = '0;
        if (mem_wr_c && (mem_waddr_c == endereco_d)) begin
            rd_d = mem_wdata_c;
        end else if (in_range(endereco_d)) begin
            rd_d = mem_q[IW'(endereco_d)];
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        cnt_d      = cnt_q;
        modo_d     = modo_q;
        first_d    = first_q;
        press_d    = press_q;
        armed_d    = (botoes == '0);

        case (state_q)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) begin
                    state_d    = PREPARA;
                    rodada_d   = '0;
                    endereco_d = '0;
                    cnt_d      = '0;
                    modo_d     = modo;
                    first_d    = 1'b1;
                end
            end
            PREPARA: begin
                cnt_d   = '0;
                state_d = modo_q ? ESPERA_NOVO : MOSTRA;
            end
            MOSTRA: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = APAGA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            APAGA: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (endereco_q == rodada_q) begin
                        endereco_d = '0;
                        state_d    = ESPERA;
                    end else begin
                        endereco_d = endereco_q + AW'(1);
                        state_d    = MOSTRA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ESPERA: begin
                // Press beats a simultaneous timeout; the timer idles while a button is held
                if (press_c) begin
                    press_d = botoes;
                    cnt_d   = '0;
                    state_d = REGISTRA;
                end else if (botoes == '0) begin
                    if (cnt_q == TO_LAST) begin
                        state_d = FIM_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            REGISTRA: begin
                state_d = COMPARA;
            end
            COMPARA: begin
                if (!is_onehot(press_q) || (press_q != rd_q)) begin
                    state_d = FIM_ERRO;
                end else if (endereco_q < rodada_q) begin
                    endereco_d = endereco_q + AW'(1);
                    cnt_d      = '0;
                    state_d    = ESPERA;
                end else begin
                    state_d = PROXIMO;
                end
            end
            PROXIMO: begin
                cnt_d = '0;
                if (rodada_q == RODADA_MAX) begin
                    state_d = FIM_ACERTO;
                end else if (!modo_q) begin
                    rodada_d   = rodada_q + AW'(1);
                    endereco_d = '0;
                    state_d    = MOSTRA;
                end else begin
                    state_d = ESPERA_NOVO;
                end
            end
            ESPERA_NOVO: begin
                if (press_c) begin
                    press_d = botoes;
                    cnt_d   = '0;
                    state_d = is_onehot(botoes) ? ESCREVE : FIM_ERRO;
                end else if (botoes == '0) begin
                    if (cnt_q == TO_LAST) begin
                        state_d = FIM_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ESCREVE: begin
                // First symbol of a session lands at address 0 without advancing the round
                if (!first_q) begin
                    rodada_d = rodada_q + AW'(1);
                end
                first_d    = 1'b0;
                endereco_d = '0;
                cnt_d      = '0;
                state_d    = MOSTRA;
            end
            default: begin
                state_d = INICIAL;
            end
        endcase
    end

    // Outputs registered from the next state so they line up with db_estado
    always_comb begin
        leds_d    = (state_d == MOSTRA) ? rd_d : '0;
        pronto_d  = (state_d == FIM_ACERTO) || (state_d == FIM_ERRO) ||
                    (state_d == FIM_TIMEOUT);
        acertou_d = (state_d == FIM_ACERTO);
        errou_d   = (state_d == FIM_ERRO);
        timeout_d = (state_d == FIM_TIMEOUT);
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INICIAL;
            rodada_q   <= '0;
            endereco_q <= '0;
            cnt_q      <= '0;
            modo_q     <= 1'b0;
            first_q    <= 1'b0;
            armed_q    <= 1'b0;
            press_q    <= '0;
            rd_q       <= '0;
            leds_q     <= '0;
            pronto_q   <= 1'b0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rodada_q   <= rodada_d;
            endereco_q <= endereco_d;
            cnt_q      <= cnt_d;
            modo_q     <= modo_d;
            first_q    <= first_d;
            armed_q    <= armed_d;
            press_q    <= press_d;
            rd_q       <= rd_d;
            leds_q     <= leds_d;
            pronto_q   <= pronto_d;
            acertou_q  <= acertou_d;
            errou_q    <= errou_d;
            timeout_q  <= timeout_d;
        end
    end

    assign leds        = leds_q;
    assign pronto      = pronto_q;
    assign acertou     = acertou_q;
    assign errou       = errou_q;
    assign timeout     = timeout_q;
    assign db_estado   = state_q;
    assign db_rodada   = rodada_q;
    assign db_endereco = endereco_q;

endmodule

// File: tb/tb_sequencia_jogo_param.sv
// Directed bench for sequencia_jogo_param (N_BOT=4, PROF=4, TIMEOUT=20, SHOW=3).
`timescale 1ns/1ps
module tb_sequencia_jogo_param;

    localparam int unsigned N_BOT = 4;
    localparam int unsigned PROF  = 4;
    localparam int unsigned AW    = 2;

    localparam logic [3:0] S_INICIAL  = 4'h0;
    localparam logic [3:0] S_MOSTRA   = 4'h2;
    localparam logic [3:0] S_APAGA    = 4'h3;
    localparam logic [3:0] S_ESPERA   = 4'h4;
    localparam logic [3:0] S_NOVO     = 4'h8;
    localparam logic [3:0] S_ACERTO   = 4'hA;
    localparam logic [3:0] S_ERRO     = 4'hE;
    localparam logic [3:0] S_TIMEOUT  = 4'hF;

    logic             clock = 1'b0;
    logic             reset;
    logic             iniciar;
    logic             modo;
    logic [N_BOT-1:0] botoes;
    logic             carrega_we;
    logic [AW-1:0]    carrega_addr;
    logic [N_BOT-1:0] carrega_dado;
    logic [N_BOT-1:0] leds;
    logic             pronto, acertou, errou, timeout;
    logic [3:0]       db_estado;
    logic [AW-1:0]    db_rodada, db_endereco;

    int n_checks = 0;
    int n_fail   = 0;

    sequencia_jogo_param #(
        .N_BOT(N_BOT), .PROF(PROF), .AW(AW), .TIMEOUT_CYC(20), .SHOW_CYC(3)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
        .botoes(botoes), .carrega_we(carrega_we), .carrega_addr(carrega_addr),
        .carrega_dado(carrega_dado), .leds(leds), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado), .db_rodada(db_rodada), .db_endereco(db_endereco)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input string tag);
        int n = 0;
        while (db_estado != s && n < 300) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, 32'(db_estado), 32'(s));
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [N_BOT-1:0] d);
        @(negedge clock);
        carrega_we = 1'b1; carrega_addr = a; carrega_dado = d;
        @(negedge clock);
        carrega_we = 1'b0;
    endtask

    task automatic start(input logic m);
        @(negedge clock);
        iniciar = 1'b1; modo = m;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic press(input logic [N_BOT-1:0] v);
        @(negedge clock);
        botoes = v;
        @(negedge clock);
        botoes = '0;
        @(negedge clock);
    endtask

    // One symbol: lit for exactly 3 cycles, then dark gap
    task automatic expect_show(input logic [N_BOT-1:0] sym);
        wait_state(S_MOSTRA, "enter_mostra");
        for (int k = 0; k < 3; k++) begin
            check_eq("show_leds", 32'(leds), 32'(sym));
            @(negedge clock);
        end
        check_eq("gap_state", 32'(db_estado), 32'(S_APAGA));
        check_eq("gap_leds", 32'(leds), 0);
    endtask

    task automatic replay(input logic [N_BOT-1:0] v);
        wait_state(S_ESPERA, "enter_espera");
        press(v);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [N_BOT-1:0] seq [4];
        int n;
        seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h4; seq[3] = 4'h8;

        reset = 1'b1; iniciar = 1'b0; modo = 1'b0; botoes = '0;
        carrega_we = 1'b0; carrega_addr = '0; carrega_dado = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_state", 32'(db_estado), 32'(S_INICIAL));
        check_eq("rst_leds", 32'(leds), 0);
        check_eq("rst_flags", 32'({pronto, acertou, errou, timeout}), 0);
        check_eq("rst_rodada", 32'(db_rodada), 0);

        // Full preloaded game: rounds 0..3 replayed correctly
        for (int i = 0; i < 4; i++) load(AW'(i), seq[i]);
        start(1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i <= r; i++) expect_show(seq[i]);
            for (int i = 0; i <= r; i++) replay(seq[i]);
        end
        wait_state(S_ACERTO, "win_state");
        check_eq("win_flags", 32'({pronto, acertou, errou, timeout}), 32'(4'b1100));
        check_eq("win_rodada", 32'(db_rodada), 3);

        // Wrong symbol in round 1
        start(1'b0);
        expect_show(4'h1);
        replay(4'h1);
        expect_show(4'h1);
        expect_show(4'h2);
        replay(4'h2);
        wait_state(S_ERRO, "err_state");
        check_eq("err_flags", 32'({pronto, acertou, errou, timeout}), 32'(4'b1010));
        check_eq("err_rodada", 32'(db_rodada), 1);

        // No press after round-0 display: 20 cycles in ESPERA then timeout
        start(1'b0);
        expect_show(4'h1);
        wait_state(S_ESPERA, "to_espera");
        n = 0;
        while (db_estado == S_ESPERA && n < 100) begin
            n++;
            @(negedge clock);
        end
        check_eq("to_cycles", 32'(n), 20);
        check_eq("to_state", 32'(db_estado), 32'(S_TIMEOUT));
        check_eq("to_flags", 32'({pronto, acertou, errou, timeout}), 32'(4'b1001));

        // Player-extended sequence 4,1,8
        start(1'b1);
        wait_state(S_NOVO, "novo0");
        press(4'h4);
        expect_show(4'h4);
        check_eq("ext_rodada0", 32'(db_rodada), 0);
        replay(4'h4);
        wait_state(S_NOVO, "novo1");
        press(4'h1);
        expect_show(4'h4);
        expect_show(4'h1);
        check_eq("ext_rodada1", 32'(db_rodada), 1);
        replay(4'h4);
        replay(4'h1);
        wait_state(S_NOVO, "novo2");
        press(4'h8);
        expect_show(4'h4);
        expect_show(4'h1);
        expect_show(4'h8);
        check_eq("ext_rodada2", 32'(db_rodada), 2);

        // Button held across ESPERA entry, plus a preload attempt during ESPERA
        botoes = 4'h4;
        wait_state(S_ESPERA, "held_espera");
        repeat (2) @(negedge clock);
        carrega_we = 1'b1; carrega_addr = '0; carrega_dado = 4'h2;
        @(negedge clock);
        carrega_we = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("held_no_press", 32'(db_estado), 32'(S_ESPERA));
        botoes = '0;
        @(negedge clock);
        replay(4'h4);
        replay(4'h1);
        replay(4'h8);
        wait_state(S_NOVO, "novo3");
        // Two-hot symbol offered as a new entry
        press(4'h3);
        wait_state(S_ERRO, "novo_bad");
        check_eq("novo_bad_errou", 32'(errou), 1);

        // Two-hot replay press; mem[0] must still be 4 despite the ignored preload
        start(1'b0);
        expect_show(4'h4);
        replay(4'h3);
        wait_state(S_ERRO, "twohot_state");
        check_eq("twohot_errou", 32'(errou), 1);

        // Start ignored mid-show, then reset mid-MOSTRA
        start(1'b0);
        wait_state(S_MOSTRA, "pre_rst");
        iniciar = 1'b1; modo = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check_eq("ini_ignored", 32'(db_estado), 32'(S_MOSTRA));
        reset = 1'b1;
        @(negedge clock);
        check_eq("mrst_state", 32'(db_estado), 32'(S_INICIAL));
        check_eq("mrst_leds", 32'(leds), 0);
        check_eq("mrst_flags", 32'({pronto, acertou, errou, timeout}), 0);
        reset = 1'b0;
        start(1'b0);
        expect_show(4'h4);
        replay(4'h4);
        expect_show(4'h4);
        expect_show(4'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
